// File: rtl/fpu_requester.sv
// fpu_requester
//   Accepts one floating-point command at a time from an upstream valid/ready
//   port, presents it to an FPU over a four-phase handshake, collects the
//   result and offers it downstream on a valid/ready response port. Illegal
//   opcodes and FPU stalls longer than TIMEOUT cycles produce an error
//   response (rsp_err=1, rsp_result=all ones). All outputs are registered or
//   decoded from the state register only.
//
// Ports
//   clock, reset            : single clock, asynchronous active-low reset
//   cmd_valid/ready         : upstream command handshake
//   cmd_op, cmd_a, cmd_b    : opcode (0 add, 1 sub, 2 mul, 3 div), operands
//   fpu_operation, fpu_data_a, fpu_data_b : latched command toward the FPU
//   fpu_input_rdy/ack       : operand handshake with the FPU
//   fpu_output_rdy/ack      : result handshake with the FPU
//   fpu_result              : FPU result
//   rsp_valid/ready         : downstream response handshake
//   rsp_result, rsp_err     : captured result or error indication
//   done_count              : responses delivered (wraps at 16 bits)

module fpu_requester #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [3:0]  fpu_operation,
    output logic [31:0] fpu_data_a,
    output logic [31:0] fpu_data_b,
    output logic        fpu_input_rdy,
    input  logic        fpu_input_ack,
    input  logic        fpu_output_rdy,
    output logic        fpu_output_ack,
    input  logic [31:0] fpu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic [15:0] done_count
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        ACK,
        RESP
    } state_t;

    // Abort fires on the edge at which the counter would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic [15:0] done_q, done_d;
    logic [7:0]  tmo_q, tmo_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            err_q       <= err_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = done_q;
        tmo_d    = tmo_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q is only set in IDLE, and stays low for the
                // first cycle after reset release.
                if (cmd_valid && cmd_ready_q) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if (cmd_op[3:2] != 2'b00) begin
                        result_d = '1;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end else begin
                        tmo_d   = '0;
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (fpu_input_ack) begin
                    tmo_d   = '0;
                    state_d = WAIT_RES;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d    = '0;
                    result_d = '1;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            WAIT_RES: begin
                if (fpu_output_rdy) begin
                    result_d = fpu_result;
                    err_d    = 1'b0;
                    state_d  = ACK;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d    = '0;
                    result_d = '1;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ACK: begin
                if (!fpu_output_rdy) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready      = cmd_ready_q;
    assign fpu_operation  = op_q;
    assign fpu_data_a     = a_q;
    assign fpu_data_b     = b_q;
    assign fpu_input_rdy  = (state_q == ISSUE);
    assign fpu_output_ack = (state_q == ACK);
    assign rsp_valid      = (state_q == RESP);
    assign rsp_result     = result_q;
    assign rsp_err        = err_q;
    assign done_count     = done_q;

endmodule

// File: tb/tb_fpu_requester.sv
// Directed bench for fpu_requester: a table of commands with hand-computed
// FPU replies and expected responses, plus hand-written sequences for
// timeouts, response backpressure and asynchronous reset mid-operation.
// The bench itself plays the FPU and the downstream consumer.

module tb_fpu_requester;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  fpu_operation;
    logic [31:0] fpu_data_a;
    logic [31:0] fpu_data_b;
    logic        fpu_input_rdy;
    logic        fpu_input_ack;
    logic        fpu_output_rdy;
    logic        fpu_output_ack;
    logic [31:0] fpu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [15:0] done_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_done = '0;

    fpu_requester #(.TIMEOUT(8)) dut (
        .clock         (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .fpu_operation (fpu_operation),
        .fpu_data_a    (fpu_data_a),
        .fpu_data_b    (fpu_data_b),
        .fpu_input_rdy (fpu_input_rdy),
        .fpu_input_ack (fpu_input_ack),
        .fpu_output_rdy(fpu_output_rdy),
        .fpu_output_ack(fpu_output_ack),
        .fpu_result    (fpu_result),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_err       (rsp_err),
        .done_count    (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] fpu_res;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand and result handshakes must never overlap.
    always @(negedge clk) begin
        if (reset) chk("rdy_ack_exclusive", 32'(fpu_input_rdy & fpu_output_ack), 32'd0);
    end

    // One command at minimum latency; ack_hold keeps fpu_output_rdy high for
    // extra cycles in ACK, rsp_hold delays rsp_ready for extra RESP cycles.
    task automatic run_vec(input vec_t v, input int unsigned ack_hold, input int unsigned rsp_hold);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'hA;
        cmd_a     = 32'hDEAD_BEEF;
        cmd_b     = 32'hCAFE_F00D;
        if (v.op > 4'd3) begin
            chk("illegal_no_input_rdy", 32'(fpu_input_rdy), 32'd0);
        end else begin
            chk("issue_input_rdy", 32'(fpu_input_rdy), 32'd1);
            chk("issue_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("issue_op", 32'(fpu_operation), 32'(v.op));
            chk("issue_a", fpu_data_a, v.a);
            chk("issue_b", fpu_data_b, v.b);
            fpu_input_ack = 1'b1;
            @(negedge clk);
            fpu_input_ack = 1'b0;
            chk("wait_input_rdy", 32'(fpu_input_rdy), 32'd0);
            chk("wait_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
            fpu_output_rdy = 1'b1;
            fpu_result     = v.fpu_res;
            @(negedge clk);
            fpu_result = 32'h0BAD_0BAD;
            chk("ack_output_ack", 32'(fpu_output_ack), 32'd1);
            chk("ack_cmd_ready", 32'(cmd_ready), 32'd0);
            for (int unsigned i = 0; i < ack_hold; i++) begin
                @(negedge clk);
                chk("ack_hold_output_ack", 32'(fpu_output_ack), 32'd1);
                chk("ack_hold_rsp_valid", 32'(rsp_valid), 32'd0);
            end
            fpu_output_rdy = 1'b0;
            @(negedge clk);
            chk("resp_output_ack", 32'(fpu_output_ack), 32'd0);
        end
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_result", rsp_result, v.exp_res);
        chk("resp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("resp_done_before", 32'(done_count), 32'(exp_done));
        for (int unsigned i = 0; i < rsp_hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_result", rsp_result, v.exp_res);
            chk("hold_rsp_err", 32'(rsp_err), 32'(v.exp_err));
            chk("hold_done", 32'(done_count), 32'(exp_done));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_done  = exp_done + 16'd1;
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_done", 32'(done_count), 32'(exp_done));
        chk("after_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    // Response delivery after an abort.
    task automatic consume_err_resp(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd1);
        chk({tag, "_rsp_result"}, rsp_result, 32'hFFFF_FFFF);
        chk({tag, "_input_rdy"}, 32'(fpu_input_rdy), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_done  = exp_done + 16'd1;
        chk({tag, "_done"}, 32'(done_count), 32'(exp_done));
    endtask

    vec_t vecs[7];

    initial begin
        // 2.0=40000000 4.0=40800000 1.0=3F800000
        vecs[0] = '{op: 4'h2, a: 32'h4000_0000, b: 32'h4000_0000, fpu_res: 32'h4080_0000, exp_res: 32'h4080_0000, exp_err: 1'b0};
        vecs[1] = '{op: 4'h3, a: 32'h4080_0000, b: 32'h4000_0000, fpu_res: 32'h4000_0000, exp_res: 32'h4000_0000, exp_err: 1'b0};
        vecs[2] = '{op: 4'h1, a: 32'h4080_0000, b: 32'h4000_0000, fpu_res: 32'h4000_0000, exp_res: 32'h4000_0000, exp_err: 1'b0};
        vecs[3] = '{op: 4'h0, a: 32'h3F80_0000, b: 32'h3F80_0000, fpu_res: 32'h4000_0000, exp_res: 32'h4000_0000, exp_err: 1'b0};
        vecs[4] = '{op: 4'h7, a: 32'h1234_5678, b: 32'h9ABC_DEF0, fpu_res: 32'h0000_0000, exp_res: 32'hFFFF_FFFF, exp_err: 1'b1};
        vecs[5] = '{op: 4'h4, a: 32'h3F80_0000, b: 32'h3F80_0000, fpu_res: 32'h0000_0000, exp_res: 32'hFFFF_FFFF, exp_err: 1'b1};
        vecs[6] = '{op: 4'hF, a: 32'h0000_0001, b: 32'h0000_0002, fpu_res: 32'h0000_0000, exp_res: 32'hFFFF_FFFF, exp_err: 1'b1};

        reset          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_op         = '0;
        cmd_a          = '0;
        cmd_b          = '0;
        fpu_input_ack  = 1'b0;
        fpu_output_rdy = 1'b0;
        fpu_result     = '0;
        rsp_ready      = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_input_rdy", 32'(fpu_input_rdy), 32'd0);
        chk("rst_output_ack", 32'(fpu_output_ack), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_done", 32'(done_count), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Table: mul, div and sub back-to-back, add, illegal opcodes
        foreach (vecs[i]) run_vec(vecs[i], 0, 0);

        // ACK held while fpu_output_rdy stays high; RESP held for 10 cycles
        run_vec('{op: 4'h2, a: 32'h3F80_0000, b: 32'h4080_0000, fpu_res: 32'h4080_0000,
                  exp_res: 32'h4080_0000, exp_err: 1'b0}, 3, 10);

        // ISSUE timeout: no input_ack; a stray fpu_output_rdy is ignored
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'h2;
        cmd_a     = 32'h4000_0000;
        cmd_b     = 32'h4000_0000;
        @(negedge clk);
        cmd_valid      = 1'b0;
        fpu_output_rdy = 1'b1;
        fpu_result     = 32'h1234_5678;
        chk("tmo_issue_input_rdy", 32'(fpu_input_rdy), 32'd1);
        for (int unsigned i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("tmo_issue_input_rdy", 32'(fpu_input_rdy), 32'd1);
            chk("tmo_issue_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("tmo_issue_output_ack", 32'(fpu_output_ack), 32'd0);
        end
        @(negedge clk);
        fpu_output_rdy = 1'b0;
        consume_err_resp("tmo_issue");

        // WAIT_RES timeout: operands taken, result never arrives
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'h0;
        @(negedge clk);
        cmd_valid     = 1'b0;
        fpu_input_ack = 1'b1;
        @(negedge clk);
        fpu_input_ack = 1'b0;
        chk("tmo_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int unsigned i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("tmo_wait_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("tmo_wait_input_rdy", 32'(fpu_input_rdy), 32'd0);
        end
        @(negedge clk);
        consume_err_resp("tmo_wait");

        // Asynchronous reset while in WAIT_RES
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'h3;
        cmd_a     = 32'h4080_0000;
        cmd_b     = 32'h4000_0000;
        @(negedge clk);
        cmd_valid     = 1'b0;
        fpu_input_ack = 1'b1;
        @(negedge clk);
        fpu_input_ack = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("arst_input_rdy", 32'(fpu_input_rdy), 32'd0);
        chk("arst_output_ack", 32'(fpu_output_ack), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_err", 32'(rsp_err), 32'd0);
        chk("arst_rsp_result", rsp_result, 32'd0);
        chk("arst_op", 32'(fpu_operation), 32'd0);
        chk("arst_a", fpu_data_a, 32'd0);
        chk("arst_b", fpu_data_b, 32'd0);
        chk("arst_done", 32'(done_count), 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        exp_done = '0;
        @(negedge clk);
        chk("arst_release_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_no_response", 32'(rsp_valid), 32'd0);
        run_vec(vecs[0], 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
